// File: rtl/error_count_tree.sv
// Pipelined read-vs-expected comparator: XOR, then a registered fan-in-2 OR tree,
// with a valid/address pipe alongside and run statistics for a RAM test controller.
module error_count_tree #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 10,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   clear_i,
   input  logic                   in_valid_i,
   input  logic [DATA_WIDTH-1:0]  read_i,
   input  logic [DATA_WIDTH-1:0]  expected_i,
   input  logic [ADDR_WIDTH-1:0]  addr_i,
   output logic                   out_valid_o,
   output logic                   error_o,
   output logic [ADDR_WIDTH-1:0]  out_addr_o,
   output logic [COUNT_WIDTH-1:0] fail_count_o,
   output logic                   first_fail_valid_o,
   output logic [ADDR_WIDTH-1:0]  first_fail_addr_o,
   output logic [DATA_WIDTH-1:0]  bit_fail_mask_o
);

   localparam int LATENCY = (DATA_WIDTH <= 2) ? 1 : $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] diff;
   assign diff = read_i ^ expected_i;

   // Stage s consumes ceil(DW/2^(s-1)) bits and produces ceil(DW/2^s); the last stage is 1 bit.
   for (genvar s = 1; s <= LATENCY; s++) begin : g_stg
      localparam int PW = (DATA_WIDTH + (1 << (s-1)) - 1) >> (s-1);
      localparam int SW = (PW + 1) / 2;
      logic [PW-1:0] src;
      logic [SW-1:0] lvl_d;
      logic [SW-1:0] lvl_q;
      logic                  vld_q;
      logic [ADDR_WIDTH-1:0] addr_q;

      if (s == 1) begin : g_src0
         assign src = diff;
      end else begin : g_srcn
         assign src = g_stg[s-1].lvl_q;
      end

      for (genvar j = 0; j < SW; j++) begin : g_pair
         if (2*j + 1 < PW) begin : g_or
            assign lvl_d[j] = src[2*j] | src[2*j+1];
         end else begin : g_pass
            assign lvl_d[j] = src[2*j];
         end
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) lvl_q <= '0;
         else          lvl_q <= lvl_d;
      end

      if (s == 1) begin : g_tag0
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               vld_q  <= 1'b0;
               addr_q <= '0;
            end else begin
               vld_q  <= in_valid_i;
               addr_q <= addr_i;
            end
         end
      end else begin : g_tagn
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               vld_q  <= 1'b0;
               addr_q <= '0;
            end else begin
               vld_q  <= g_stg[s-1].vld_q;
               addr_q <= g_stg[s-1].addr_q;
            end
         end
      end
   end

   // Tree data is don't-care on invalid slots, so error is gated by the valid tag.
   logic hit;
   assign hit         = g_stg[LATENCY].vld_q & g_stg[LATENCY].lvl_q[0];
   assign out_valid_o = g_stg[LATENCY].vld_q;
   assign error_o     = hit;
   assign out_addr_o  = g_stg[LATENCY].addr_q;

   logic [COUNT_WIDTH-1:0] fail_q, fail_d;
   logic                   ffv_q;
   logic [ADDR_WIDTH-1:0]  ffa_q;
   logic [DATA_WIDTH-1:0]  mask_q;

   assign fail_d = (fail_q == {COUNT_WIDTH{1'b1}}) ? fail_q : fail_q + 1'b1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         fail_q <= '0;
         ffv_q  <= 1'b0;
         ffa_q  <= '0;
         mask_q <= '0;
      end else if (clear_i) begin
         fail_q <= '0;
         ffv_q  <= 1'b0;
         ffa_q  <= '0;
         mask_q <= '0;
      end else begin
         if (hit) begin
            fail_q <= fail_d;
            if (!ffv_q) begin
               ffv_q <= 1'b1;
               ffa_q <= g_stg[LATENCY].addr_q;
            end
         end
         if (in_valid_i) mask_q <= mask_q | diff;
      end
   end

   assign fail_count_o       = fail_q;
   assign first_fail_valid_o = ffv_q;
   assign first_fail_addr_o  = ffa_q;
   assign bit_fail_mask_o    = mask_q;

endmodule

// File: tb/tb_error_count_tree.sv
// Randomized bench for error_count_tree: four instances (DW 8, DW 8 with a 4-bit
// counter, DW 5, DW 1) share stimulus and are checked against a delay-line model.
module tb_error_count_tree;

   typedef struct { bit v; bit [9:0] a; bit err; } ent_t;

   localparam int LAT [4] = '{3, 3, 3, 1};
   localparam int WID [4] = '{8, 8, 5, 1};
   localparam int CMX [4] = '{65535, 15, 65535, 65535};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic [7:0] rd, ex;
   logic [9:0] addr;

   logic [3:0] ov, er, ffv;
   logic [9:0] oa [4];
   logic [9:0] ffa [4];
   logic [15:0] fc0, fc2, fc3;
   logic [3:0]  fc1;
   logic [7:0]  mk0, mk1;
   logic [4:0]  mk2;
   logic [0:0]  mk3;

   int n_cmp = 0;
   int n_mis = 0;

   ent_t     dq [4][$];
   int       m_cnt [4];
   bit       m_ffv [4];
   bit [9:0] m_ffa [4];
   bit [7:0] m_mask [4];

   always #5 clk = ~clk;

   error_count_tree #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .COUNT_WIDTH(16)) u_d8 (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .in_valid_i(in_valid),
      .read_i(rd), .expected_i(ex), .addr_i(addr),
      .out_valid_o(ov[0]), .error_o(er[0]), .out_addr_o(oa[0]), .fail_count_o(fc0),
      .first_fail_valid_o(ffv[0]), .first_fail_addr_o(ffa[0]), .bit_fail_mask_o(mk0));

   error_count_tree #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .COUNT_WIDTH(4)) u_c4 (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .in_valid_i(in_valid),
      .read_i(rd), .expected_i(ex), .addr_i(addr),
      .out_valid_o(ov[1]), .error_o(er[1]), .out_addr_o(oa[1]), .fail_count_o(fc1),
      .first_fail_valid_o(ffv[1]), .first_fail_addr_o(ffa[1]), .bit_fail_mask_o(mk1));

   error_count_tree #(.DATA_WIDTH(5), .ADDR_WIDTH(10), .COUNT_WIDTH(16)) u_d5 (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .in_valid_i(in_valid),
      .read_i(rd[4:0]), .expected_i(ex[4:0]), .addr_i(addr),
      .out_valid_o(ov[2]), .error_o(er[2]), .out_addr_o(oa[2]), .fail_count_o(fc2),
      .first_fail_valid_o(ffv[2]), .first_fail_addr_o(ffa[2]), .bit_fail_mask_o(mk2));

   error_count_tree #(.DATA_WIDTH(1), .ADDR_WIDTH(10), .COUNT_WIDTH(16)) u_d1 (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .in_valid_i(in_valid),
      .read_i(rd[0:0]), .expected_i(ex[0:0]), .addr_i(addr),
      .out_valid_o(ov[3]), .error_o(er[3]), .out_addr_o(oa[3]), .fail_count_o(fc3),
      .first_fail_valid_o(ffv[3]), .first_fail_addr_o(ffa[3]), .bit_fail_mask_o(mk3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   function automatic bit [7:0] wmask(input int i);
      return 8'((16'd1 << WID[i]) - 16'd1);
   endfunction

   function automatic logic [31:0] obs_cnt(input int i);
      case (i)
         0:       return 32'(fc0);
         1:       return 32'(fc1);
         2:       return 32'(fc2);
         default: return 32'(fc3);
      endcase
   endfunction

   function automatic logic [31:0] obs_mask(input int i);
      case (i)
         0:       return 32'(mk0);
         1:       return 32'(mk1);
         2:       return 32'(mk2);
         default: return 32'(mk3);
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         dq[i].delete();
         for (int k = 0; k < LAT[i]; k++) dq[i].push_back('{v: 1'b0, a: 10'd0, err: 1'b0});
         m_cnt[i] = 0; m_ffv[i] = 1'b0; m_ffa[i] = '0; m_mask[i] = '0;
      end
   endtask

   // Statistics use the result visible before the edge; then the delay line advances.
   task automatic model_edge();
      for (int i = 0; i < 4; i++) begin
         ent_t h;
         bit [7:0] d;
         h = dq[i][0];
         d = (rd ^ ex) & wmask(i);
         if (clear) begin
            m_cnt[i] = 0; m_ffv[i] = 1'b0; m_ffa[i] = '0; m_mask[i] = '0;
         end else begin
            if (h.v && h.err) begin
               if (m_cnt[i] < CMX[i]) m_cnt[i]++;
               if (!m_ffv[i]) begin m_ffv[i] = 1'b1; m_ffa[i] = h.a; end
            end
            if (in_valid) m_mask[i] |= d;
         end
         void'(dq[i].pop_front());
         dq[i].push_back('{v: in_valid, a: addr, err: (d != 0)});
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("out_valid[%0d]", i), 32'(ov[i]),   32'(dq[i][0].v));
         chk($sformatf("error[%0d]", i),     32'(er[i]),   32'(dq[i][0].v & dq[i][0].err));
         chk($sformatf("out_addr[%0d]", i),  32'(oa[i]),   32'(dq[i][0].a));
         chk($sformatf("fail_cnt[%0d]", i),  obs_cnt(i),   32'(m_cnt[i]));
         chk($sformatf("ff_valid[%0d]", i),  32'(ffv[i]),  32'(m_ffv[i]));
         chk($sformatf("ff_addr[%0d]", i),   32'(ffa[i]),  32'(m_ffa[i]));
         chk($sformatf("mask[%0d]", i),      obs_mask(i),  32'(m_mask[i]));
      end
   endtask

   task automatic step(input bit v, input bit [9:0] a, input bit [7:0] r, input bit [7:0] e,
                       input bit clr);
      in_valid = v; addr = a; rd = r; ex = e; clear = clr;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 10'(k), 8'h00, 8'h00, 1'b0);
   endtask

   initial begin
      bit [7:0] w;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; rd = '0; ex = '0; addr = '0;
      model_reset();
      #12;
      check_all();
      rst_n = 1'b1;

      // Back-to-back compares, only addr 2 mismatches in bit 0.
      for (int k = 0; k < 4; k++) begin
         w = 8'($urandom);
         if (k == 2) step(1'b1, 10'd2, 8'h5A, 8'h5B, 1'b0);
         else        step(1'b1, 10'(k), w, w, 1'b0);
      end
      idle(3);
      chk("t1_count", 32'(fc0), 32'd1);
      chk("t1_ffaddr", 32'(ffa[0]), 32'd2);
      chk("t1_mask", 32'(mk0), 32'h01);

      // First failure address is sticky.
      step(1'b0, 10'd0, 8'h00, 8'h00, 1'b1);
      step(1'b1, 10'd7, 8'hF0, 8'h30, 1'b0);
      step(1'b1, 10'd9, 8'h06, 8'h02, 1'b0);
      idle(3);
      chk("t2_count", 32'(fc0), 32'd2);
      chk("t2_ffaddr", 32'(ffa[0]), 32'd7);
      chk("t2_mask", 32'(mk0), 32'hC4);

      // Counter saturation on the 4-bit instance.
      step(1'b0, 10'd0, 8'h00, 8'h00, 1'b1);
      for (int k = 0; k < 20; k++) step(1'b1, 10'(k + 32), 8'hFF, 8'h00, 1'b0);
      idle(3);
      chk("t3_sat", 32'(fc1), 32'd15);
      chk("t3_nosat", 32'(fc0), 32'd20);

      // Clear while failures are in flight: they still count after the clear.
      step(1'b0, 10'd0, 8'h00, 8'h00, 1'b1);
      step(1'b1, 10'd100, 8'h80, 8'h00, 1'b0);
      step(1'b1, 10'd101, 8'h81, 8'h00, 1'b0);
      step(1'b1, 10'd102, 8'h11, 8'h00, 1'b1);
      chk("t4_cleared", 32'(fc0), 32'd0);
      idle(4);
      chk("t4_count", 32'(fc0), 32'd3);
      chk("t4_ffaddr", 32'(ffa[0]), 32'd100);

      // Invalid slots with mismatching data change nothing.
      for (int k = 0; k < 5; k++) step(1'b0, 10'(k), 8'($urandom), 8'($urandom) ^ 8'h01, 1'b0);
      idle(3);
      chk("t5_count", 32'(fc0), 32'd3);

      // MSB-only mismatch on the narrow instances.
      step(1'b0, 10'd0, 8'h00, 8'h00, 1'b1);
      step(1'b1, 10'd55, 8'h10, 8'h00, 1'b0);
      idle(1);
      chk("t6_d5_early", 32'(er[2]), 32'd0);
      idle(1);
      chk("t6_d5_lat3", 32'(er[2]), 32'd1);
      step(1'b1, 10'd66, 8'h01, 8'h00, 1'b0);
      chk("t6_d1_lat1", 32'(er[3]), 32'd1);
      idle(3);

      // Random traffic with occasional clears.
      for (int k = 0; k < 400; k++) begin
         w = 8'($urandom);
         step(1'($urandom_range(0, 3) != 0), 10'($urandom),
              w, ($urandom_range(0, 2) == 0) ? 8'($urandom) : w,
              $urandom_range(0, 31) == 0);
      end

      // Reset mid-stream: outputs drop at once, in-flight compares vanish.
      step(1'b1, 10'd200, 8'hFF, 8'h00, 1'b0);
      step(1'b1, 10'd201, 8'hFF, 8'h00, 1'b0);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      chk("rst_ov", 32'(ov[0]), 32'd0);
      in_valid = 1'b1; rd = 8'hFF; ex = 8'h00;
      @(posedge clk);
      @(negedge clk);
      check_all();
      #1 rst_n = 1'b1;
      idle(4);
      chk("rst_count", 32'(fc0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
